// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the instruction stream toward decode.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign_err;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign_err,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign_err,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, credit-limited imem requests and an in-order {inst, pc} FIFO.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus_io
);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;
   // Stale responses can pile up across back-to-back redirects, so drop is wider than DEPTH.
   localparam int unsigned DW  = 8;
   localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [DW-1:0] drop_t;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic [31:0] inst_mem_q [DEPTH];
   logic [31:0] pc_mem_q   [DEPTH];
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   cnt_t        live_q, live_d;
   drop_t       drop_q, drop_d;
   logic        run_q;
   logic        halted_q, halted_d;
   logic        err_q, err_d;

   logic        req_valid_s;
   logic        inst_valid_s;
   logic        hs_s;
   logic        pop_s;
   logic        push_s;
   logic        rsp_drop_s;
   logic        redir_bad_s;
   logic [31:0] redir_pc_s;
   logic [CW:0] credit_s;

   // run_q keeps the request line low until the first edge after reset release.
   assign credit_s    = CW1'(count_q) + CW1'(live_q);
   assign req_valid_s = run_q && !halted_q && (credit_s < DEPTH_C);
   assign inst_valid_s = (count_q != '0);

   assign bus_io.imem_req_valid = req_valid_s;
   assign bus_io.imem_req_addr  = pc_q;
   assign bus_io.inst_valid     = inst_valid_s;
   assign bus_io.inst           = inst_mem_q[rd_ptr_q];
   assign bus_io.inst_pc        = pc_mem_q[rd_ptr_q];
   assign bus_io.misalign_err   = err_q;

   // Next-state for PC, FIFO pointers, in-flight accounting and error flags.
   always_comb begin
      hs_s       = req_valid_s && bus_io.imem_req_ready;
      pop_s      = inst_valid_s && bus_io.inst_ready;
      rsp_drop_s = bus_io.imem_rsp_valid && (drop_q != '0);
      push_s     = bus_io.imem_rsp_valid && (drop_q == '0) && !bus_io.redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
      redir_bad_s = (bus_io.redirect_pc[1:0] != 2'b00);
      redir_pc_s  = bus_io.redirect_pc;
`else
      redir_bad_s = 1'b0;
      redir_pc_s  = bus_io.redirect_pc & 32'hFFFF_FFFC;
`endif

      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      live_d   = live_q;
      drop_d   = drop_q;
      halted_d = halted_q;
      err_d    = err_q;

      if (bus_io.redirect_valid) begin
         // Every request still out in memory, kept or not, must be discarded on return.
         pc_d     = redir_pc_s;
         rsp_pc_d = redir_pc_s;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         live_d   = '0;
         drop_d   = drop_q + DW'(live_q) + DW'(hs_s) - DW'(bus_io.imem_rsp_valid);
         halted_d = halted_q || redir_bad_s;
         err_d    = err_q || redir_bad_s;
      end else begin
         pc_d     = hs_s   ? pc_q + 32'd4     : pc_q;
         rsp_pc_d = push_s ? rsp_pc_q + 32'd4 : rsp_pc_q;
         wr_ptr_d = push_s ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
         rd_ptr_d = pop_s  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
         count_d  = count_q + cnt_t'(push_s) - cnt_t'(pop_s);
         live_d   = live_q + cnt_t'(hs_s) - cnt_t'(push_s);
         drop_d   = drop_q - DW'(rsp_drop_s);
      end
   end

   // State registers and FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= '0;
         drop_q   <= '0;
         run_q    <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= 32'h0000_0000;
            pc_mem_q[i]   <= 32'h0000_0000;
         end
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         live_q   <= live_d;
         drop_q   <= drop_d;
         run_q    <= 1'b1;
         halted_q <= halted_d;
         err_q    <= err_d;
         if (push_s) begin
            inst_mem_q[wr_ptr_q] <= bus_io.imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table after reset, then hand-written
// stall, redirect, wrap and misalignment sequences against an in-order memory model.
module tb_fetch_unit;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   lat    = 1;
   int   cyc    = 0;

   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic [31:0] got_pc    [$];
   logic [31:0] got_dat   [$];

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C;
   endfunction

   // Memory: accepts on handshake, answers in order after lat cycles.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + lat);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
         end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memword(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
         end
      end
   end

   // Records every word accepted by decode.
   always @(negedge clk) begin
      if (rst_n && bus.inst_valid && bus.inst_ready) begin
         got_pc.push_back(bus.inst_pc);
         got_dat.push_back(bus.inst);
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      repeat (2) next_cycle();
      @(negedge clk);
      chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk1("rst_inst_valid", bus.inst_valid, 1'b0);
      chk32("rst_inst", bus.inst, 32'h0);
      chk32("rst_inst_pc", bus.inst_pc, 32'h0);
      chk1("rst_misalign", bus.misalign_err, 1'b0);
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic check_pops(input string name, input int base, input logic [31:0] start,
                             input int n);
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         e = start + 32'(4 * i);
         if (base + i < got_pc.size()) begin
            chk32({name, "_pc"}, got_pc[base + i], e);
            chk32({name, "_data"}, got_dat[base + i], memword(e));
         end else begin
            checks++;
            errors++;
            $display("FAIL %s: pop %0d missing, got none expected pc %h", name, i, e);
         end
      end
   endtask

   task automatic redirect_seq(input string name, input int lat_i, input int c1,
                               input logic [31:0] p1, input int c2, input logic [31:0] p2,
                               input logic exp_rv, input logic [31:0] exp_addr,
                               input logic exp_err, output int base);
      lat = lat_i;
      bus.inst_ready     = 1'b1;
      bus.imem_req_ready = 1'b1;
      do_reset();
      base = got_pc.size();
      for (int c = 1; c <= c2; c++) begin
         next_cycle();
         bus.redirect_valid = (c == c1) || (c == c2);
         bus.redirect_pc    = (c == c2) ? p2 : p1;
      end
      next_cycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk1({name, "_iv_after"}, bus.inst_valid, 1'b0);
      chk1({name, "_rv_after"}, bus.imem_req_valid, exp_rv);
      chk32({name, "_addr_after"}, bus.imem_req_addr, exp_addr);
      chk1({name, "_err_after"}, bus.misalign_err, exp_err);
   endtask

   task automatic drain();
      repeat (20) next_cycle();
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        inst_rdy;
      logic        req_rdy;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vec [9];

   initial begin
      int base;
      int hs_cnt;
      logic last_rv;

      rst_n = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;

      // Cycle k = k-th edge after reset release; 1-cycle memory, credit of 2.
      vec[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
      vec[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
      vec[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
      vec[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
      vec[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
      vec[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
      vec[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
      vec[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
      vec[8] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};

      lat = 1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         bus.inst_ready     = vec[i].inst_rdy;
         bus.imem_req_ready = vec[i].req_rdy;
         @(negedge clk);
         chk1($sformatf("vec%0d_rv", i), bus.imem_req_valid, vec[i].exp_rv);
         chk32($sformatf("vec%0d_addr", i), bus.imem_req_addr, vec[i].exp_addr);
         chk1($sformatf("vec%0d_iv", i), bus.inst_valid, vec[i].exp_iv);
         if (vec[i].exp_iv) begin
            chk32($sformatf("vec%0d_pc", i), bus.inst_pc, vec[i].exp_pc);
            chk32($sformatf("vec%0d_inst", i), bus.inst, memword(vec[i].exp_pc));
         end
         next_cycle();
      end

      // Decode stalled: only DEPTH requests go out, then nothing is lost on release.
      lat = 1;
      bus.inst_ready     = 1'b0;
      bus.imem_req_ready = 1'b1;
      do_reset();
      base    = got_pc.size();
      hs_cnt  = 0;
      last_rv = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) hs_cnt++;
         last_rv = bus.imem_req_valid;
         next_cycle();
      end
      chk32("stall_req_count", 32'(hs_cnt), 32'd2);
      chk1("stall_rv_low", last_rv, 1'b0);
      bus.inst_ready = 1'b1;
      drain();
      check_pops("stall_release", base, 32'h0000_0000, 4);

      // 3-cycle memory, redirect with two requests in flight.
      redirect_seq("lat3_redir", 3, 3, 32'h0000_0100, 3, 32'h0000_0100,
                   1'b1, 32'h0000_0100, 1'b0, base);
      drain();
      check_pops("lat3_redir", base, 32'h0000_0100, 2);

      // Redirect coinciding with a response and a request handshake.
      redirect_seq("same_cycle", 1, 2, 32'h0000_0200, 2, 32'h0000_0200,
                   1'b1, 32'h0000_0200, 1'b0, base);
      drain();
      check_pops("same_cycle", base, 32'h0000_0200, 3);

      // Back-to-back redirects: last target wins.
      redirect_seq("b2b", 3, 3, 32'h0000_0300, 4, 32'h0000_0400,
                   1'b1, 32'h0000_0400, 1'b0, base);
      drain();
      check_pops("b2b", base, 32'h0000_0400, 2);

      // PC wrap past the top of the address space.
      redirect_seq("wrap", 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,
                   1'b1, 32'hFFFF_FFFC, 1'b0, base);
      drain();
      check_pops("wrap", base, 32'hFFFF_FFFC, 3);

`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_seq("misalign", 1, 1, 32'h0000_0102, 1, 32'h0000_0102,
                   1'b0, 32'h0000_0102, 1'b1, base);
      drain();
      chk1("misalign_rv_held", bus.imem_req_valid, 1'b0);
      chk1("misalign_iv_held", bus.inst_valid, 1'b0);
      chk1("misalign_sticky", bus.misalign_err, 1'b1);
      chk32("misalign_no_pops", 32'(got_pc.size() - base), 32'd0);
`else
      redirect_seq("misalign", 1, 1, 32'h0000_0102, 1, 32'h0000_0102,
                   1'b1, 32'h0000_0100, 1'b0, base);
      drain();
      chk1("misalign_err_tied", bus.misalign_err, 1'b0);
      check_pops("misalign", base, 32'h0000_0100, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
